// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
// reg_file_param : 1-write / 2-read register file with registered reads,
//                  write-first bypass, optional zero register and clear sweep
// Revision       : 1.0
// ============================================================================
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              clear,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              busy
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_ok;

  // A write is architecturally visible only in IDLE and never to a hardwired r0.
  assign wr_ok = we && (state_q == ST_IDLE) && !(ZERO_REG && (wr_addr == '0));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    rs_data_d = '0;
    rt_data_d = '0;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;

    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
      cnt_d     = cnt_q + ADDR_W'(1);
      if (cnt_q == LAST_IDX) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    end else begin
      mem_we = wr_ok;

      if (wr_ok && (wr_addr == rs_addr))      rs_data_d = wr_data;
      else if (ZERO_REG && (rs_addr == '0))   rs_data_d = '0;
      else                                    rs_data_d = mem_q[rs_addr];

      if (wr_ok && (wr_addr == rt_addr))      rt_data_d = wr_data;
      else if (ZERO_REG && (rt_addr == '0))   rt_data_d = '0;
      else                                    rt_data_d = mem_q[rt_addr];

      if (clear) begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      busy_q    <= 1'b1;
      rs_data_q <= '0;
      rt_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
    end
  end

  // Storage is deliberately not reset; the sweep zeroes it after reset release.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rs_data = rs_data_q;
  assign rt_data = rt_data_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ============================================================================
// tb_reg_file_param : self-checking bench for reg_file_param (32x64, ZERO_REG=1)
// Revision          : 1.0
// ============================================================================
module tb_reg_file_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk;
  logic              reset_n;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              clear;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  // Architectural view of the register contents.
  logic [DATA_W-1:0] model [DEPTH];

  reg_file_param #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(1'b1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (we),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rs_addr(rs_addr),
    .rt_addr(rt_addr),
    .clear  (clear),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] expect_read(input logic [ADDR_W-1:0] ra,
                                                    input logic wen,
                                                    input logic [ADDR_W-1:0] wa,
                                                    input logic [DATA_W-1:0] wd);
    if (ra == 0) return '0;
    if (wen && wa == ra) return wd;
    return model[ra];
  endfunction

  task automatic idle_inputs();
    we = 1'b0; wr_addr = '0; wr_data = '0; rs_addr = '0; rt_addr = '0; clear = 1'b0;
  endtask

  task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    we = 1'b1; wr_addr = a; wr_data = d;
    step();
    we = 1'b0;
    if (a != 0) model[a] = d;
  endtask

  // Counts observed cycles with busy high, starting from the current cycle.
  task automatic count_busy(output int n, input bit check_zero_out);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      rs_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      rt_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      step();
      if (check_zero_out && busy === 1'b1) begin
        checks++;
        if (rs_data !== '0 || rt_data !== '0) begin
          failures++;
          $display("FAIL sweep_outputs rs=%h rt=%h required 0", rs_data, rt_data);
        end
      end
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      rs_addr = ADDR_W'(i);
      rt_addr = ADDR_W'(DEPTH - 1 - i);
      step();
      checks++;
      if (rs_data !== '0 || rt_data !== '0) begin
        failures++;
        $display("FAIL %s r%0d rs=%h rt=%h required 0", tag, i, rs_data, rt_data);
      end
    end
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0;
    idle_inputs();
    repeat (3) step();
    checks++;
    if (rs_data !== '0 || rt_data !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_state rs=%h rt=%h busy=%b required 0/0/1", rs_data, rt_data, busy);
    end
    reset_n = 1'b1;
    count_busy(n, 1'b1);
    checks++;
    if (n != 64) begin
      failures++;
      $display("FAIL reset_sweep_len busy_cycles=%0d required 64", n);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    read_all_zero("reset_read");
  endtask

  task automatic test_write_read();
    write_reg(6'd5, 32'hDEADBEEF);
    rs_addr = 6'd5; rt_addr = 6'd5;
    step();
    checks++;
    if (rs_data !== 32'hDEADBEEF || rt_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_read rs=%h rt=%h required deadbeef", rs_data, rt_data);
    end
  endtask

  task automatic test_bypass();
    write_reg(6'd3, 32'hA5A5A5A5);
    we = 1'b1; wr_addr = 6'd9; wr_data = 32'h12345678;
    rs_addr = 6'd9; rt_addr = 6'd3;
    step();
    we = 1'b0; model[9] = 32'h12345678;
    checks++;
    if (rs_data !== 32'h12345678 || rt_data !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL bypass rs=%h rt=%h required 12345678/a5a5a5a5", rs_data, rt_data);
    end
    // both ports bypassing together
    we = 1'b1; wr_addr = 6'd40; wr_data = 32'h0BADF00D;
    rs_addr = 6'd40; rt_addr = 6'd40;
    step();
    we = 1'b0; model[40] = 32'h0BADF00D;
    checks++;
    if (rs_data !== 32'h0BADF00D || rt_data !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL dual_bypass rs=%h rt=%h required 0badf00d", rs_data, rt_data);
    end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; wr_addr = '0; wr_data = 32'hFFFFFFFF; rs_addr = '0; rt_addr = '0;
    step();
    we = 1'b0;
    checks++;
    if (rs_data !== '0 || rt_data !== '0) begin
      failures++;
      $display("FAIL zero_bypass rs=%h rt=%h required 0", rs_data, rt_data);
    end
    step();
    checks++;
    if (rs_data !== '0 || rt_data !== '0) begin
      failures++;
      $display("FAIL zero_read rs=%h rt=%h required 0", rs_data, rt_data);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] exp_rs, exp_rt;
    for (int c = 0; c < 300; c++) begin
      we      = 1'($urandom_range(0, 1));
      wr_addr = ($urandom_range(0, 7) == 0) ? 6'd0 : ADDR_W'($urandom_range(0, DEPTH - 1));
      wr_data = $urandom;
      rs_addr = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
      rt_addr = ($urandom_range(0, 3) == 0) ? rs_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
      exp_rs  = expect_read(rs_addr, we, wr_addr, wr_data);
      exp_rt  = expect_read(rt_addr, we, wr_addr, wr_data);
      step();
      if (we && wr_addr != 0) model[wr_addr] = wr_data;
      checks++;
      if (rs_data !== exp_rs || rt_data !== exp_rt || busy !== 1'b0) begin
        failures++;
        $display("FAIL random c=%0d rs=%h/%h rt=%h/%h busy=%b (actual/required)",
                 c, rs_data, exp_rs, rt_data, exp_rt, busy);
      end
    end
    we = 1'b0;
  endtask

  task automatic test_clear_sweep();
    int n;
    for (int i = 1; i < DEPTH; i++) write_reg(ADDR_W'(i), 32'h8000_0000 | DATA_W'(i * 32'h01010101));
    rs_addr = 6'd17; rt_addr = 6'd33;
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (busy !== 1'b1 || rs_data !== model[17] || rt_data !== model[33]) begin
      failures++;
      $display("FAIL clear_start busy=%b rs=%h rt=%h required 1/%h/%h",
               busy, rs_data, rt_data, model[17], model[33]);
    end
    // sweep with a write at cycles 2 and 20 and a second clear at cycle 10
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      we      = (n == 2 || n == 20);
      wr_addr = 6'd7;
      wr_data = 32'h55;
      clear   = (n == 10);
      rs_addr = 6'd7;
      rt_addr = ADDR_W'($urandom_range(1, DEPTH - 1));
      step();
      if (busy === 1'b1) begin
        checks++;
        if (rs_data !== '0 || rt_data !== '0) begin
          failures++;
          $display("FAIL clear_outputs n=%0d rs=%h rt=%h required 0", n, rs_data, rt_data);
        end
      end
    end
    idle_inputs();
    checks++;
    if (n != 64) begin
      failures++;
      $display("FAIL clear_sweep_len busy_cycles=%0d required 64", n);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    read_all_zero("clear_read");
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    write_reg(6'd12, 32'hCAFE0012);
    rs_addr = 6'd12; rt_addr = 6'd12;
    step();
    checks++;
    if (rs_data !== 32'hCAFE0012) begin
      failures++;
      $display("FAIL pre_reset_read rs=%h required cafe0012", rs_data);
    end
    // asynchronous: outputs clear before the next clock edge
    reset_n = 1'b0;
    #2;
    checks++;
    if (rs_data !== '0 || rt_data !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL async_reset rs=%h rt=%h busy=%b required 0/0/1", rs_data, rt_data, busy);
    end
    step();
    reset_n = 1'b1;
    repeat (30) step();
    reset_n = 1'b0;
    #2;
    checks++;
    if (rs_data !== '0 || rt_data !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_sweep_reset rs=%h rt=%h busy=%b required 0/0/1", rs_data, rt_data, busy);
    end
    repeat (2) step();
    reset_n = 1'b1;
    count_busy(n, 1'b1);
    checks++;
    if (n != 64) begin
      failures++;
      $display("FAIL restart_sweep_len busy_cycles=%0d required 64", n);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    read_all_zero("restart_read");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_random();
    test_clear_sweep();
    test_random();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
